// File: rtl/writeback_pkg.sv
// Shared constants and types for the Y86-64 write-back stage: icodes, register
// IDs, status codes and FSM encodings.
package writeback_pkg;

    localparam int NREG_DEFAULT = 15;
    localparam int WORD_DEFAULT = 64;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    typedef enum logic [2:0] {
        SAOK = 3'd1,
        SHLT = 3'd2,
        SADR = 3'd3,
        SINS = 3'd4
    } stat_e;

    typedef enum logic {
        WB_RUN    = 1'b0,
        WB_HALTED = 1'b1
    } wb_state_e;

    // Undefined status codes are folded into INS when the core stops.
    function automatic stat_e halt_stat(input logic [2:0] s);
        case (s)
            3'd2:    return SHLT;
            3'd3:    return SADR;
            default: return SINS;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2r2w.sv
// Program register file: two combinational read ports, two write ports with
// the M port winning on a collision, synchronous reset to index values.
module regfile_2r2w
    import writeback_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int WORD = WORD_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_e,
    input  logic [3:0]      adr_e,
    input  logic [WORD-1:0] dat_e,
    input  logic            we_m,
    input  logic [3:0]      adr_m,
    input  logic [WORD-1:0] dat_m,
    input  logic [3:0]      srca,
    input  logic [3:0]      srcb,
    output logic [WORD-1:0] vala,
    output logic [WORD-1:0] valb
);

    logic [WORD-1:0] regs [NREG];

    // NOTE: this array is reset because software relies on r[i]=i after reset;
    // that forces flops rather than a RAM macro, acceptable at 15 entries.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= WORD'(i);
            end
        end else begin
            // NOTE: non-blocking writes; the later M assignment overrides E on
            // the same index, which is exactly the popq %rsp priority.
            if (we_e && int'(adr_e) < NREG) regs[adr_e] <= dat_e;
            if (we_m && int'(adr_m) < NREG) regs[adr_m] <= dat_m;
        end
    end

    assign vala = (int'(srca) < NREG) ? regs[srca] : '0;
    assign valb = (int'(srcb) < NREG) ? regs[srcb] : '0;

endmodule

// File: rtl/writeback.sv
// Y86-64 write-back stage: RUN/HALTED status FSM, retire counter and gated
// commits into the architectural register file.
module writeback
    import writeback_pkg::*;
#(
    parameter int NREG = NREG_DEFAULT,
    parameter int WORD = WORD_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [3:0]      icode_i,
    input  logic [2:0]      stat_i,
    input  logic [3:0]      dstE_i,
    input  logic [3:0]      dstM_i,
    input  logic [WORD-1:0] valE_i,
    input  logic [WORD-1:0] valM_i,
    input  logic [3:0]      srcA_i,
    input  logic [3:0]      srcB_i,
    output logic [WORD-1:0] valA_o,
    output logic [WORD-1:0] valB_o,
    output logic [2:0]      stat_o,
    output logic            halted_o,
    output logic [63:0]     retired_o
);

    wb_state_e   state_q, state_d;
    stat_e       stat_q, stat_d;
    logic [63:0] retired_q, retired_d;
    logic        commit;

    // The instruction code is carried for debug visibility only.
    logic icode_unused;
    assign icode_unused = ^icode_i;

    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        stat_d    = stat_q;
        retired_d = retired_q;
        commit    = 1'b0;
        case (state_q)
            WB_RUN: begin
                if (stat_i == SAOK) begin
                    commit    = 1'b1;
                    retired_d = retired_q + 64'd1;
                end else begin
                    stat_d  = halt_stat(stat_i);
                    state_d = WB_HALTED;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= WB_RUN;
            stat_q    <= SAOK;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

    regfile_2r2w #(
        .NREG (NREG),
        .WORD (WORD)
    ) u_regfile (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we_e  (commit && dstE_i != RNONE),
        .adr_e (dstE_i),
        .dat_e (valE_i),
        .we_m  (commit && dstM_i != RNONE),
        .adr_m (dstM_i),
        .dat_m (valM_i),
        .srca  (srcA_i),
        .srcb  (srcB_i),
        .vala  (valA_o),
        .valb  (valB_o)
    );

    assign stat_o    = stat_q;
    assign halted_o  = (state_q == WB_HALTED);
    assign retired_o = retired_q;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: table of vectors whose expected pre-edge
// outputs flow through a scoreboard queue, plus a counter-wrap sequence.
module tb_writeback;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  icode_i;
    logic [2:0]  stat_i;
    logic [3:0]  dstE_i, dstM_i;
    logic [63:0] valE_i, valM_i;
    logic [3:0]  srcA_i, srcB_i;
    logic [63:0] valA_o, valB_o;
    logic [2:0]  stat_o;
    logic        halted_o;
    logic [63:0] retired_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    writeback dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .icode_i   (icode_i),
        .stat_i    (stat_i),
        .dstE_i    (dstE_i),
        .dstM_i    (dstM_i),
        .valE_i    (valE_i),
        .valM_i    (valM_i),
        .srcA_i    (srcA_i),
        .srcB_i    (srcB_i),
        .valA_o    (valA_o),
        .valB_o    (valB_o),
        .stat_o    (stat_o),
        .halted_o  (halted_o),
        .retired_o (retired_o)
    );

    // Inputs applied for one cycle, and the outputs expected just before the
    // edge that consumes them (i.e. the state left by all earlier vectors).
    typedef struct {
        logic        rst;
        logic [2:0]  stat;
        logic [3:0]  dste;
        logic [63:0] vale;
        logic [3:0]  dstm;
        logic [63:0] valm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
        logic [63:0] exa;
        logic [63:0] exb;
        logic [2:0]  exstat;
        logic        exh;
        logic [63:0] exret;
    } vec_t;

    typedef struct {
        int          idx;
        logic [63:0] a;
        logic [63:0] b;
        logic [2:0]  st;
        logic        h;
        logic [63:0] ret;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic rst, input logic [2:0] stat,
                                input logic [3:0] dste, input logic [63:0] vale,
                                input logic [3:0] dstm, input logic [63:0] valm,
                                input logic [3:0] srca, input logic [3:0] srcb,
                                input logic [63:0] exa, input logic [63:0] exb,
                                input logic [2:0] exstat, input logic exh,
                                input logic [63:0] exret);
        vec_t v;
        v.rst = rst; v.stat = stat; v.dste = dste; v.vale = vale;
        v.dstm = dstm; v.valm = valm; v.srca = srca; v.srcb = srcb;
        v.exa = exa; v.exb = exb; v.exstat = exstat; v.exh = exh; v.exret = exret;
        return v;
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: empty queue at compare");
            return;
        end
        e = sb.pop_front();
        check("valA",    e.idx, valA_o,          e.a);
        check("valB",    e.idx, valB_o,          e.b);
        check("stat",    e.idx, 64'(stat_o),     64'(e.st));
        check("halted",  e.idx, 64'(halted_o),   64'(e.h));
        check("retired", e.idx, retired_o,       e.ret);
    endtask

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        @(negedge clk_i);
        rst_i   = v.rst;
        icode_i = 4'h6;
        stat_i  = v.stat;
        dstE_i  = v.dste;
        valE_i  = v.vale;
        dstM_i  = v.dstm;
        valM_i  = v.valm;
        srcA_i  = v.srca;
        srcB_i  = v.srcb;
        e.idx = idx; e.a = v.exa; e.b = v.exb; e.st = v.exstat;
        e.h = v.exh; e.ret = v.exret;
        sb.push_back(e);
        #2;
        compare_pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
    localparam logic [3:0] RN = 4'hF;

    initial begin
        rst_i = 1'b1; icode_i = 4'h1; stat_i = AOK;
        dstE_i = RN; dstM_i = RN; valE_i = '0; valM_i = '0;
        srcA_i = 4'd0; srcB_i = 4'd0;
        repeat (2) @(posedge clk_i);

        //        rst   stat dstE valE      dstM valM      sA     sB    exA       exB       st   h     ret
        vecs.push_back(mk(0, AOK, RN,  0,        RN,  0,        4'd3,  RN,   3,        0,        AOK, 0,    0));
        vecs.push_back(mk(0, AOK, 2,   'hDEAD,   5,   'hBEEF,   4'd2,  4'd5, 2,        5,        AOK, 0,    1));
        vecs.push_back(mk(0, AOK, 4,   'h100,    4,   'h200,    4'd2,  4'd5, 'hDEAD,   'hBEEF,   AOK, 0,    2));
        vecs.push_back(mk(0, AOK, RN,  0,        RN,  0,        4'd4,  RN,   'h200,    0,        AOK, 0,    3));
        vecs.push_back(mk(0, AOK, 14,  'hAAAA,   0,   'h1234,   4'd14, 4'd0, 14,       0,        AOK, 0,    4));
        vecs.push_back(mk(0, HLT, 1,   'h55,     3,   'h77,     4'd14, 4'd0, 'hAAAA,   'h1234,   AOK, 0,    5));
        vecs.push_back(mk(0, AOK, 1,   'h99,     RN,  0,        4'd1,  4'd3, 1,        3,        HLT, 1,    5));
        vecs.push_back(mk(0, AOK, RN,  0,        1,   'h99,     4'd1,  RN,   1,        0,        HLT, 1,    5));
        vecs.push_back(mk(1, AOK, 6,   'h66,     RN,  0,        4'd6,  4'd4, 6,        'h200,    HLT, 1,    5));
        vecs.push_back(mk(0, AOK, RN,  0,        RN,  0,        4'd6,  4'd4, 6,        4,        AOK, 0,    0));
        vecs.push_back(mk(0, ADR, 7,   'h77,     RN,  0,        4'd7,  4'd2, 7,        2,        AOK, 0,    1));
        vecs.push_back(mk(0, AOK, 7,   'h88,     RN,  0,        4'd7,  RN,   7,        0,        ADR, 1,    1));
        vecs.push_back(mk(1, AOK, RN,  0,        RN,  0,        4'd0,  4'd14, 0,       14,       ADR, 1,    1));
        vecs.push_back(mk(0, 3'd0, 2,  'h22,     RN,  0,        4'd1,  4'd1, 1,        1,        AOK, 0,    0));
        vecs.push_back(mk(1, AOK, RN,  0,        RN,  0,        4'd2,  4'd3, 2,        3,        INS, 1,    0));
        vecs.push_back(mk(0, INS, 9,   'h99,     RN,  0,        4'd9,  RN,   9,        0,        AOK, 0,    0));
        vecs.push_back(mk(1, AOK, RN,  0,        RN,  0,        4'd9,  RN,   9,        0,        INS, 1,    0));
        vecs.push_back(mk(0, 3'd7, RN, 0,        RN,  0,        4'd8,  RN,   8,        0,        AOK, 0,    0));
        vecs.push_back(mk(1, AOK, RN,  0,        RN,  0,        4'd8,  RN,   8,        0,        INS, 1,    0));
        vecs.push_back(mk(0, AOK, RN,  0,        RN,  0,        4'd8,  RN,   8,        0,        AOK, 0,    0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Counter wrap: preload all-ones, then one AOK commit must roll to zero.
        @(negedge clk_i);
        rst_i = 1'b0; stat_i = 3'd0; dstE_i = RN; dstM_i = RN;
        force dut.retired_q = '1;
        #1;
        release dut.retired_q;
        #1;
        check("wrap_pre", 0, retired_o, 64'hFFFF_FFFF_FFFF_FFFF);
        stat_i = AOK;
        @(negedge clk_i);
        #2;
        check("wrap_post", 0, retired_o, 64'd0);
        check("wrap_halted", 0, 64'(halted_o), 64'd0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: %0d entries left over", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
